// File: rtl/licznik_odczyt_disp_if.sv
// Bundle of the count input and the published count/display outputs.
// The master side drives the raw count; the slave side is the consumer.
interface licznik_odczyt_disp_if;
  logic [3:0] cnt_in;
  logic [3:0] cnt_q;
  logic       upd;
  logic       wrap;
  logic [3:0] wrap_cnt;
  logic [6:0] seg;
  logic [1:0] an;

  modport master (
    output cnt_in,
    input  cnt_q,
    input  upd,
    input  wrap,
    input  wrap_cnt,
    input  seg,
    input  an
  );

  modport slave (
    input  cnt_in,
    output cnt_q,
    output upd,
    output wrap,
    output wrap_cnt,
    output seg,
    output an
  );
endinterface

// File: rtl/licznik_odczyt_disp.sv
// Consumer of the ripple counter: resynchronises and debounces the count,
// publishes it with update/wrap strobes and drives a 2-digit 7-segment display.
module licznik_odczyt_disp #(
  parameter int STABLE_CYCLES = 4,
  parameter int REFRESH_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  licznik_odczyt_disp_if.slave  bus
);

  localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);
  localparam int RC_W = $clog2(REFRESH_DIV);
  localparam logic [RC_W-1:0] RC_MAX = RC_W'(REFRESH_DIV - 1);

  logic [3:0]        s1;
  logic [3:0]        s2;
  logic [3:0]        cand;
  logic [STAB_W-1:0] stab;
  logic              accept;
  logic              decrease;
  logic [3:0]        cnt_q;
  logic              upd;
  logic              wrap;
  logic [3:0]        wrap_cnt;
  logic [RC_W-1:0]   rcnt;
  logic              sel;
  logic [3:0]        shown;
  logic [6:0]        seg;
  logic [1:0]        an;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'h0:    r = 7'b1000000;
      4'h1:    r = 7'b1111001;
      4'h2:    r = 7'b0100100;
      4'h3:    r = 7'b0110000;
      4'h4:    r = 7'b0011001;
      4'h5:    r = 7'b0010010;
      4'h6:    r = 7'b0000010;
      4'h7:    r = 7'b1111000;
      4'h8:    r = 7'b0000000;
      4'h9:    r = 7'b0010000;
      4'hA:    r = 7'b0001000;
      4'hB:    r = 7'b0000011;
      4'hC:    r = 7'b1000110;
      4'hD:    r = 7'b0100001;
      4'hE:    r = 7'b0000110;
      default: r = 7'b0001110;
    endcase
    return r;
  endfunction

  // Two-flop synchroniser; s1 may be metastable so only s2 feeds logic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 4'h0;
      s2 <= 4'h0;
    end else begin
      s1 <= bus.cnt_in;
      s2 <= s1;
    end
  end

  // Ripple intermediates never persist, so a code must stay put to be trusted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand <= 4'h0;
      stab <= '0;
    end else if (s2 != cand) begin
      cand <= s2;
      stab <= '0;
    end else if (stab < STAB_MAX) begin
      stab <= stab + STAB_W'(1);
    end
  end

  assign accept   = (stab == STAB_MAX) && (s2 == cand) && (cand != cnt_q);
  assign decrease = cand < cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= 4'h0;
      upd      <= 1'b0;
      wrap     <= 1'b0;
      wrap_cnt <= 4'h0;
    end else begin
      upd  <= accept;
      wrap <= accept && decrease;
      if (accept) begin
        cnt_q <= cand;
      end
      if (accept && decrease) begin
        wrap_cnt <= wrap_cnt + 4'd1;
      end
    end
  end

  // Digit slot timer runs freely, unaffected by filter activity.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rcnt <= '0;
      sel  <= 1'b0;
    end else if (rcnt == RC_MAX) begin
      rcnt <= '0;
      sel  <= ~sel;
    end else begin
      rcnt <= rcnt + RC_W'(1);
    end
  end

  always_comb begin
    shown = sel ? wrap_cnt : cnt_q;
  end

  // Enable and segments share one register stage so they never disagree.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= 2'b10;
      seg <= 7'b1000000;
    end else begin
      an  <= sel ? 2'b01 : 2'b10;
      seg <= hex7(shown);
    end
  end

  assign bus.cnt_q    = cnt_q;
  assign bus.upd      = upd;
  assign bus.wrap     = wrap;
  assign bus.wrap_cnt = wrap_cnt;
  assign bus.seg      = seg;
  assign bus.an       = an;

endmodule
